// File: rtl/rl_ring_tap_if.sv
// rl_ring_tap_if: ring-side and bridge-side beat buses of rl_ring_tap.
// master: the tap itself (accepts ring beats, sources particle beats).
// slave : the surrounding fabric (ring producer and rl_lr_bridge).
interface rl_ring_tap_if #(
  parameter int unsigned CELLW  = 6,
  parameter int unsigned PADDRW = 4,
  parameter int unsigned PDATAW = 16
) ();
  // ring input side
  logic              rvalid;
  logic              rready;
  logic [CELLW-1:0]  rcell;
  logic              rnull;
  logic              rcell_last;
  logic [PDATAW-1:0] rdata;
  // bridge output side
  logic              pvalid;
  logic              pready;
  logic [PADDRW-1:0] paddr;
  logic              pwe;
  logic [PDATAW-1:0] pwdata;
  logic              plast;

  modport master (
    input  rvalid, rcell, rnull, rcell_last, rdata, pready,
    output rready, pvalid, paddr, pwe, pwdata, plast
  );

  modport slave (
    output rvalid, rcell, rnull, rcell_last, rdata, pready,
    input  rready, pvalid, paddr, pwe, pwdata, plast
  );
endinterface

// File: rtl/rl_ring_tap.sv
// rl_ring_tap: takes particle beats off the RL input ring, assigns sequential
// particle-memory addresses from 0, buffers them in a small FIFO and presents
// them to rl_lr_bridge. plast marks the beat on which the last of TOTCELLS
// cells reported end-of-cell.
// Optional build macro RL_RING_TAP_CELLCHK_EN: tracks which cells have already
// reported rcell_last, ignores repeats for the cell count and flags them on
// the sticky dupcell output.

package md_lr_pkg;
  localparam int unsigned MAXNUMP = 16;
  localparam int unsigned PDATAW  = 16;
  localparam int unsigned PADDRW  = $clog2(MAXNUMP);
endpackage

module rl_ring_tap
  import md_lr_pkg::*;
#(
  parameter int unsigned TOTCELLS  = 32'd64,
  parameter int unsigned FIFODEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  rl_ring_tap_if.master   bus,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic [PADDRW:0] nump
`ifdef RL_RING_TAP_CELLCHK_EN
  ,
  output logic            dupcell
`endif
);

  localparam int unsigned CELLW = $clog2(TOTCELLS);
  localparam int unsigned AW    = $clog2(FIFODEPTH);

  localparam logic [CELLW:0]  CELLS_M1  = (CELLW+1)'(TOTCELLS - 1);
  localparam logic [PADDRW:0] ADDR_MAX  = (PADDRW+1)'(MAXNUMP);
  localparam logic [AW:0]     FIFO_FULL = (AW+1)'(FIFODEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [PADDRW-1:0] paddr;
    logic              pwe;
    logic [PDATAW-1:0] pwdata;
    logic              plast;
  } beat_t;

  // control state
  state_t          state_q, state_d;
  logic [PADDRW:0] addr_q,  addr_d;
  logic [CELLW:0]  cells_q, cells_d;
  logic            ovf_q,   ovf_d;
  logic            done_q,  done_d;
`ifdef RL_RING_TAP_CELLCHK_EN
  logic [TOTCELLS-1:0] seen_q, seen_d;
  logic                dup_q,  dup_d;
`endif

  // output FIFO
  beat_t           mem_q [FIFODEPTH];
  beat_t           mem_d [FIFODEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     cnt_q,  cnt_d;

  // datapath helpers
  logic  fifo_full;
  logic  fifo_empty;
  logic  rready;
  logic  acc;
  logic  pop;
  logic  push;
  logic  is_part;
  logic  drop;
  logic  wr;
  logic  cell_inc;
  logic  final_beat;
  beat_t head;
  beat_t new_beat;

`ifndef RL_RING_TAP_CELLCHK_EN
  // without the bitvector the cell id carries no information for the tap
  logic unused_rcell;
  assign unused_rcell = ^bus.rcell;
`endif

  // next-state, accept/push/pop decisions and FIFO bookkeeping
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cells_d  = cells_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
`ifdef RL_RING_TAP_CELLCHK_EN
    seen_d   = seen_q;
    dup_d    = dup_q;
`endif
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;

    fifo_full  = (cnt_q == FIFO_FULL);
    fifo_empty = (cnt_q == '0);
    rready     = (state_q == S_STREAM) && !fifo_full;
    acc        = bus.rvalid && rready;
    head       = mem_q[rptr_q];
    pop        = !fifo_empty && bus.pready;

    is_part  = !bus.rnull;
    drop     = is_part && (addr_q == ADDR_MAX);
    wr       = is_part && !drop;
`ifdef RL_RING_TAP_CELLCHK_EN
    cell_inc = bus.rcell_last && !seen_q[bus.rcell];
`else
    cell_inc = bus.rcell_last;
`endif
    final_beat = acc && cell_inc && (cells_q == CELLS_M1);
    push       = acc && (wr || final_beat);

    // null and dropped final beats still need a plast carrier: a pwe=0 marker
    new_beat.paddr  = addr_q[PADDRW-1:0];
    new_beat.pwe    = wr;
    new_beat.pwdata = wr ? bus.rdata : '0;
    new_beat.plast  = final_beat;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          addr_d  = '0;
          cells_d = '0;
          ovf_d   = 1'b0;
`ifdef RL_RING_TAP_CELLCHK_EN
          seen_d  = '0;
          dup_d   = 1'b0;
`endif
        end
      end
      S_STREAM: begin
        if (acc) begin
          if (wr)       addr_d  = addr_q + 1'b1;
          if (drop)     ovf_d   = 1'b1;
          if (cell_inc) cells_d = cells_q + 1'b1;
`ifdef RL_RING_TAP_CELLCHK_EN
          if (bus.rcell_last) begin
            if (seen_q[bus.rcell]) dup_d = 1'b1;
            seen_d[bus.rcell] = 1'b1;
          end
`endif
          if (final_beat) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head.plast) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[wptr_q] = new_beat;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // state registers; FIFO storage needs no reset since pointers gate it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cells_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef RL_RING_TAP_CELLCHK_EN
      seen_q  <= '0;
      dup_q   <= 1'b0;
`endif
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cells_q <= cells_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
`ifdef RL_RING_TAP_CELLCHK_EN
      seen_q  <= seen_d;
      dup_q   <= dup_d;
`endif
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
    mem_q <= mem_d;
  end

  // bus outputs; head fields forced to zero while the FIFO is empty
  always_comb begin
    bus.rready = rready;
    bus.pvalid = !fifo_empty;
    bus.paddr  = fifo_empty ? '0 : head.paddr;
    bus.pwe    = !fifo_empty && head.pwe;
    bus.pwdata = fifo_empty ? '0 : head.pwdata;
    bus.plast  = !fifo_empty && head.plast;
    busy       = (state_q != S_IDLE);
    done       = done_q;
    ovf        = ovf_q;
    nump       = addr_q;
`ifdef RL_RING_TAP_CELLCHK_EN
    dupcell    = dup_q;
`endif
  end

endmodule
